remote_key_link: RTL and testbench
==================================

// Module: remote_key_link
// PURPOSE
//  Board-to-board key link in front of the game FSMs. TX side: stretches local
//  space/enter levels from keyboard_controller into clean, minimum-width pulses
//  on SPACE_TX/ENTER_TX. RX side: synchronises, debounces and edge-detects
//  SPACE_RX/ENTER_RX into levels and one-cycle press strobes for game_fsm and
//  turn_remote_fsm. Also flags a remote line stuck high.
// PARAMETERS
//  RX_DB_CYC    650          consecutive stable cycles before RX level accepted (10 us @65 MHz)
//  TX_HOLD_CYC  6500         minimum TX high time after local rising edge (100 us)
//  TX_GAP_CYC   6500         forced TX low time after release (100 us)
//  STUCK_CYC    325_000_000  filtered RX high this long -> fault (5 s)
// PORTS
//  clk           in   1  65 MHz system clock
//  rst           in   1  synchronous, active-high reset
//  space_local   in   1  local space level (keyboard_controller)
//  enter_local   in   1  local enter level
//  SPACE_RX      in   1  async line from remote board
//  ENTER_RX      in   1  async line from remote board
//  SPACE_TX      out  1  stretched local space to remote board
//  ENTER_TX      out  1  stretched local enter to remote board
//  space_remote  out  1  debounced remote space level
//  enter_remote  out  1  debounced remote enter level
//  space_press   out  1  one-cycle strobe on space_remote rising edge
//  enter_press   out  1  one-cycle strobe on enter_remote rising edge
//  link_fault    out  1  sticky: either filtered RX level high >= STUCK_CYC
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All outputs, sync FFs,
//    counters 0; TX FSMs in TX_IDLE. Reset mid-pulse drops TX low next cycle.
//  - Channels independent; space and enter events in the same cycle both handled.
//  - RX path per channel: 2-FF sync (reset 0) -> debounce: counter clears when
//    synced == filtered, else increments; when count == RX_DB_CYC-1 and still
//    differs, filtered <= synced, counter <= 0. Glitch < RX_DB_CYC cycles never
//    reaches filtered. press = filtered & ~filtered_d (registered).
//  - Latency: RX edge held stable -> *_remote rises RX_DB_CYC+2 cycles later,
//    *_press asserted the following cycle, exactly 1 cycle wide.
//  - Stuck detect: per-channel counter runs while filtered high, saturates at
//    STUCK_CYC, clears when low; link_fault set at saturation, cleared only by rst.
//    press strobes still generated while fault set.
//  - TX FSM per channel: TX_IDLE (tx=0): local rising edge -> TX_HOLD, cnt=0.
//    TX_HOLD (tx=1): cnt++ to TX_HOLD_CYC-1; then if local low -> TX_GAP, else
//    stay (tx follows held key). TX_GAP (tx=0): cnt to TX_GAP_CYC-1 -> TX_IDLE.
//    Rising edge during TX_GAP sets pend; pend in TX_IDLE -> TX_HOLD immediately,
//    pend cleared. Edge in TX_HOLD ignored (already high). TX registered: rises
//    1 cycle after local edge.
//  - Counter widths $clog2(param+1); no wrap (saturate or clear per above).
// STRUCTURE
//  - link_pkg: typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_GAP} tx_state_t;
//    default timing localparams shared with top_vga/tb.
//  - Sub-module link_channel (one TX FSM + RX sync/debounce/edge/stuck),
//    instantiated twice (space, enter); top ORs stuck flags into link_fault.
//  - Replaces direct SPACE_TX=space wiring and RX||btn OR in top_vga.
// TESTING (override RX_DB_CYC=4, TX_HOLD_CYC=8, TX_GAP_CYC=5, STUCK_CYC=50)
//  1 SPACE_RX 0->1 held -> space_remote=1 at +6 cycles, space_press 1 cycle at +7.
//  2 ENTER_RX 3-cycle high glitch -> enter_remote, enter_press stay 0.
//  3 space_local 1-cycle pulse -> SPACE_TX high 8 cycles, then low >= 5 cycles.
//  4 enter_local re-pressed during TX_GAP -> second 8-cycle TX pulse starts
//    immediately after gap; no pulse lost.
//  5 SPACE_RX held 60 cycles -> link_fault=1 after 50 filtered-high cycles,
//    stays 1 after RX drops; rst -> 0.
//  6 rst asserted mid TX_HOLD and with RX high -> all outputs 0 next cycle,
//    press strobe re-issued after release of rst only via fresh debounce.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and default timing for the board-to-board key link.
// Defaults assume a 65 MHz clock; the bench overrides them with short values.
package link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HOLD,
        TX_GAP
    } tx_state_t;

    localparam int RX_DB_CYC_DEF   = 650;          // 10 us
    localparam int TX_HOLD_CYC_DEF = 6500;         // 100 us
    localparam int TX_GAP_CYC_DEF  = 6500;         // 100 us
    localparam int STUCK_CYC_DEF   = 325_000_000;  // 5 s

endpackage

// File: rtl/link_channel.sv
// One key channel of the remote link: TX pulse stretcher plus RX
// synchroniser, debouncer, press-edge detector and stuck-high detector.
// Ports: clk, rst (sync, active-high); key_local (local key level);
//        rx (async remote line); tx (stretched pulse to remote);
//        remote (debounced level); press (1-cycle strobe); stuck (sticky).
module link_channel
    import link_pkg::*;
#(
    parameter int RX_DB_CYC   = RX_DB_CYC_DEF,
    parameter int TX_HOLD_CYC = TX_HOLD_CYC_DEF,
    parameter int TX_GAP_CYC  = TX_GAP_CYC_DEF,
    parameter int STUCK_CYC   = STUCK_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_local,
    input  logic rx,
    output logic tx,
    output logic remote,
    output logic press,
    output logic stuck
);

    localparam int TX_MAX  = (TX_HOLD_CYC > TX_GAP_CYC) ? TX_HOLD_CYC
                                                        : TX_GAP_CYC;
    localparam int TX_W    = $clog2(TX_MAX + 1);
    localparam int DB_W    = $clog2(RX_DB_CYC + 1);
    localparam int STUCK_W = $clog2(STUCK_CYC + 1);

    localparam logic [TX_W-1:0]    HOLD_LAST = TX_W'(TX_HOLD_CYC - 1);
    localparam logic [TX_W-1:0]    GAP_LAST  = TX_W'(TX_GAP_CYC - 1);
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(RX_DB_CYC - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYC);

    // ---------------- TX pulse stretcher ----------------
    tx_state_t       state;
    tx_state_t       state_nxt;
    logic [TX_W-1:0] tx_cnt;
    logic [TX_W-1:0] tx_cnt_nxt;
    logic            pend;
    logic            pend_nxt;
    logic            key_d;
    logic            rise;
    logic            tx_nxt;

    assign rise = key_local & ~key_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TX_IDLE;
            tx_cnt <= '0;
            pend   <= 1'b0;
            key_d  <= 1'b0;
            tx     <= 1'b0;
        end else begin
            state  <= state_nxt;
            tx_cnt <= tx_cnt_nxt;
            pend   <= pend_nxt;
            key_d  <= key_local;
            tx     <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_cnt_nxt = tx_cnt;
        pend_nxt   = pend;
        unique case (state)
            TX_IDLE: begin
                // A press remembered during the gap starts a pulse at once.
                if (rise || pend) begin
                    state_nxt  = TX_HOLD;
                    tx_cnt_nxt = '0;
                    pend_nxt   = 1'b0;
                end
            end
            TX_HOLD: begin
                // After the minimum width, TX follows a held key.
                if (tx_cnt != HOLD_LAST) begin
                    tx_cnt_nxt = tx_cnt + TX_W'(1);
                end else if (!key_local) begin
                    state_nxt  = TX_GAP;
                    tx_cnt_nxt = '0;
                end
            end
            TX_GAP: begin
                if (rise) begin
                    pend_nxt = 1'b1;
                end
                if (tx_cnt == GAP_LAST) begin
                    state_nxt  = TX_IDLE;
                    tx_cnt_nxt = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt + TX_W'(1);
                end
            end
            default: begin
                state_nxt  = TX_IDLE;
                tx_cnt_nxt = '0;
                pend_nxt   = 1'b0;
            end
        endcase
        tx_nxt = (state_nxt == TX_HOLD);
    end

    // ---------------- RX filter ----------------
    logic               sync1;
    logic               sync2;
    logic [DB_W-1:0]    db_cnt;
    logic               remote_d;
    logic [STUCK_W-1:0] stuck_cnt;
    logic [STUCK_W-1:0] stuck_cnt_nxt;

    // Counts filtered-high cycles, saturating so it never wraps.
    always_comb begin
        stuck_cnt_nxt = '0;
        if (remote) begin
            stuck_cnt_nxt = (stuck_cnt == STUCK_MAX) ? stuck_cnt
                                                     : stuck_cnt + STUCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_cnt    <= '0;
            remote    <= 1'b0;
            remote_d  <= 1'b0;
            press     <= 1'b0;
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            // Accept a new level only after it has differed for
            // RX_DB_CYC consecutive cycles.
            if (sync2 == remote) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                remote <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            remote_d  <= remote;
            press     <= remote & ~remote_d;
            stuck_cnt <= stuck_cnt_nxt;
            stuck     <= stuck | (stuck_cnt_nxt == STUCK_MAX);
        end
    end

endmodule

// File: rtl/remote_key_link.sv
// Board-to-board key link: stretches local space/enter into TX pulses and
// turns remote RX lines into debounced levels, press strobes and a fault flag.
// Ports: clk, rst (sync, active-high); space_local, enter_local (local keys);
//        SPACE_RX, ENTER_RX (async remote); SPACE_TX, ENTER_TX (to remote);
//        space_remote, enter_remote, space_press, enter_press; link_fault.
module remote_key_link
    import link_pkg::*;
#(
    parameter int RX_DB_CYC   = RX_DB_CYC_DEF,
    parameter int TX_HOLD_CYC = TX_HOLD_CYC_DEF,
    parameter int TX_GAP_CYC  = TX_GAP_CYC_DEF,
    parameter int STUCK_CYC   = STUCK_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic space_local,
    input  logic enter_local,
    input  logic SPACE_RX,
    input  logic ENTER_RX,
    output logic SPACE_TX,
    output logic ENTER_TX,
    output logic space_remote,
    output logic enter_remote,
    output logic space_press,
    output logic enter_press,
    output logic link_fault
);

    logic space_stuck;
    logic enter_stuck;

    link_channel #(
        .RX_DB_CYC   (RX_DB_CYC),
        .TX_HOLD_CYC (TX_HOLD_CYC),
        .TX_GAP_CYC  (TX_GAP_CYC),
        .STUCK_CYC   (STUCK_CYC)
    ) u_space (
        .clk       (clk),
        .rst       (rst),
        .key_local (space_local),
        .rx        (SPACE_RX),
        .tx        (SPACE_TX),
        .remote    (space_remote),
        .press     (space_press),
        .stuck     (space_stuck)
    );

    link_channel #(
        .RX_DB_CYC   (RX_DB_CYC),
        .TX_HOLD_CYC (TX_HOLD_CYC),
        .TX_GAP_CYC  (TX_GAP_CYC),
        .STUCK_CYC   (STUCK_CYC)
    ) u_enter (
        .clk       (clk),
        .rst       (rst),
        .key_local (enter_local),
        .rx        (ENTER_RX),
        .tx        (ENTER_TX),
        .remote    (enter_remote),
        .press     (enter_press),
        .stuck     (enter_stuck)
    );

    assign link_fault = space_stuck | enter_stuck;

endmodule

// File: tb/tb_remote_key_link.sv
// Self-checking bench for remote_key_link with short timing parameters.
// Table vectors, directed multi-cycle sequences and a random run vs a model.
module tb_remote_key_link;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 5;
    localparam int STK  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sl = 1'b0, el = 1'b0, srx = 1'b0, erx = 1'b0;
    logic SPACE_TX, ENTER_TX, space_remote, enter_remote;
    logic space_press, enter_press, link_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    remote_key_link #(
        .RX_DB_CYC   (DB),
        .TX_HOLD_CYC (HOLD),
        .TX_GAP_CYC  (GAP),
        .STUCK_CYC   (STK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .space_local  (sl),
        .enter_local  (el),
        .SPACE_RX     (srx),
        .ENTER_RX     (erx),
        .SPACE_TX     (SPACE_TX),
        .ENTER_TX     (ENTER_TX),
        .space_remote (space_remote),
        .enter_remote (enter_remote),
        .space_press  (space_press),
        .enter_press  (enter_press),
        .link_fault   (link_fault)
    );

    // bit 6..0: SPACE_TX ENTER_TX space_remote enter_remote
    //           space_press enter_press link_fault
    logic [6:0] obs;
    assign obs = {SPACE_TX, ENTER_TX, space_remote, enter_remote,
                  space_press, enter_press, link_fault};

    task automatic check(string name, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Number of consecutive samples (from the current one) where obs[idx]==lvl.
    task automatic run_len(input int idx, input logic lvl, input int max,
                           output int n);
        n = 0;
        while (obs[idx] == lvl && n < max) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sl = 1'b0; el = 1'b0; srx = 1'b0; erx = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int         n_edge;
    logic       m_s1[2], m_s2[2], m_f[2], m_fprev[2], m_press[2];
    logic       m_fault[2], m_lprev[2], m_on[2], m_pend[2];
    logic [DB-1:0] m_hist[2];
    int         m_run[2], m_start[2], m_end[2];

    // One clock edge. The remote level flips once the last DB synchronised
    // samples all disagree with it; TX pulses are tracked by start/end edge.
    task automatic model_step();
        logic lk[2];
        logic rxv[2];
        logic syn, rise, oldf;
        lk[0] = sl; lk[1] = el; rxv[0] = srx; rxv[1] = erx;
        n_edge++;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_f[c] = 0; m_fprev[c] = 0;
                m_press[c] = 0; m_fault[c] = 0; m_lprev[c] = 0;
                m_on[c] = 0; m_pend[c] = 0; m_hist[c] = '0;
                m_run[c] = 0; m_start[c] = 0; m_end[c] = -1000;
                continue;
            end
            syn = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = rxv[c];
            m_hist[c] = {m_hist[c][DB-2:0], syn};
            oldf = m_f[c];
            m_press[c] = oldf & ~m_fprev[c];
            m_fprev[c] = oldf;
            if (m_hist[c] == {DB{~oldf}}) m_f[c] = ~oldf;
            m_run[c] = oldf ? ((m_run[c] < STK) ? m_run[c] + 1 : STK) : 0;
            if (m_run[c] >= STK) m_fault[c] = 1'b1;
            rise = lk[c] & ~m_lprev[c];
            m_lprev[c] = lk[c];
            if (m_on[c]) begin
                if (n_edge - m_start[c] >= HOLD && !lk[c]) begin
                    m_on[c] = 1'b0;
                    m_end[c] = n_edge;
                end
            end else if (n_edge - m_end[c] <= GAP) begin
                if (rise) m_pend[c] = 1'b1;
            end else if (rise || m_pend[c]) begin
                m_on[c] = 1'b1;
                m_start[c] = n_edge;
                m_pend[c] = 1'b0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic [3:0] in;   // {sl, el, srx, erx}
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n, nl, nh;
        logic [6:0] exp_v;

        tbl[0]  = '{1'b1, 4'b1111, 7'b0000000};
        tbl[1]  = '{1'b0, 4'b1010, 7'b1000000};
        tbl[2]  = '{1'b0, 4'b0111, 7'b1100000};
        tbl[3]  = '{1'b0, 4'b0011, 7'b1100000};
        tbl[4]  = '{1'b0, 4'b0011, 7'b1100000};
        tbl[5]  = '{1'b0, 4'b0010, 7'b1100000};
        tbl[6]  = '{1'b0, 4'b0010, 7'b1110000};
        tbl[7]  = '{1'b0, 4'b0010, 7'b1110100};
        tbl[8]  = '{1'b0, 4'b0010, 7'b1110000};
        tbl[9]  = '{1'b0, 4'b0010, 7'b0110000};
        tbl[10] = '{1'b0, 4'b0010, 7'b0010000};
        tbl[11] = '{1'b0, 4'b0010, 7'b0010000};

        tick();
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r;
            {sl, el, srx, erx} = tbl[i].in;
            tick();
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // enter re-pressed during the gap: second pulse follows the gap
        do_reset();
        el = 1'b1;
        tick();
        el = 1'b0;
        run_len(5, 1'b1, 50, nh);
        check_int("enter_first_high", nh, HOLD, HOLD);
        el = 1'b1;
        tick();
        el = 1'b0;
        run_len(5, 1'b0, 50, nl);
        check_int("enter_gap_low", nl + 1, GAP, GAP + 1);
        run_len(5, 1'b1, 50, nh);
        check_int("enter_second_high", nh, HOLD, HOLD);
        run_len(5, 1'b0, 20, nl);
        check_int("enter_no_extra", nl, 20, 20);

        // remote stuck high sets a sticky fault
        do_reset();
        srx = 1'b1;
        run_len(4, 1'b0, 100, n);
        check_int("space_remote_latency", n, DB + 2, DB + 2);
        run_len(0, 1'b0, 100, n);
        check_int("fault_after_stuck", n, STK, STK);
        srx = 1'b0;
        repeat (15) tick();
        check("fault_sticky", obs & 7'b0010001, 7'b0000001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fault_reset", obs, 7'b0000000);

        // reset mid TX pulse with RX high, then a fresh debounce
        do_reset();
        srx = 1'b1;
        repeat (8) tick();
        sl = 1'b1;
        tick();
        sl = 1'b0;
        tick();
        tick();
        check("pre_reset_state", obs & 7'b1010000, 7'b1010000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_pulse_reset", obs, 7'b0000000);
        run_len(4, 1'b0, 100, n);
        check_int("redebounce_latency", n, DB + 2, DB + 2);
        check("press_not_yet", obs & 7'b1010100, 7'b0010000);
        tick();
        check("press_strobe", obs & 7'b1010100, 7'b0010100);
        tick();
        check("press_one_cycle", obs & 7'b1010100, 7'b0010000);

        // random run against the model
        n_edge = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 29) == 0) srx = ~srx;
            if ($urandom_range(0, 29) == 0) erx = ~erx;
            if ($urandom_range(0, 11) == 0) sl = ~sl;
            if ($urandom_range(0, 11) == 0) el = ~el;
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp_v = {m_on[0], m_on[1], m_f[0], m_f[1], m_press[0],
                     m_press[1], m_fault[0] | m_fault[1]};
            check($sformatf("rand%0d", i), obs, exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
